// File: rtl/tdp_ram_pkg.sv
// rtl/tdp_ram_pkg.sv - shared write-mode encodings and lane-merge helper for tdp_ram
package tdp_ram_pkg;

    // Same-port read-during-write behaviour selected by the WR_MODE parameter
    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } wr_mode_e;

    // Widest data word the merge helper handles; tdp_ram narrows the result to DATA_W
    localparam int MERGE_W = 64;

    // Take bits of new_word where bit_mask is set, keep old_word elsewhere.
    // Callers expand their lane enables into a per-bit mask before calling.
    function automatic logic [MERGE_W-1:0] lane_merge(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_W-1:0] bit_mask
    );
        return (old_word & ~bit_mask) | (new_word & bit_mask);
    endfunction

endpackage

// File: rtl/tdp_ram_outreg.sv
// rtl/tdp_ram_outreg.sv - optional per-port output/valid stage (enabled by TDP_RAM_OUT_REG_EN)
module tdp_ram_outreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              vin,
    output logic [DATA_W-1:0] dout,
    output logic              vout
);

`ifdef TDP_RAM_OUT_REG_EN
    // Extra pipeline stage: data only advances with a valid read so dout holds when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
            vout <= 1'b0;
        end else begin
            if (vin) begin
                dout <= din;
            end
            vout <= vin;
        end
    end
`else
    // Clock and reset are not needed when the stage is bypassed
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst_n;

    assign dout = din;
    assign vout = vin;
`endif

endmodule

// File: rtl/tdp_ram.sv
// rtl/tdp_ram.sv - true dual-port RAM with lane write enables, collision flag, optional output stage (TDP_RAM_OUT_REG_EN)
module tdp_ram
    import tdp_ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int BYTE_W  = 4,
    parameter int WR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [DATA_W/BYTE_W-1:0] wea,
    input  logic [ADDR_W-1:0]        addra,
    input  logic [DATA_W-1:0]        dia,
    output logic [DATA_W-1:0]        doa,
    output logic                     vala,
    input  logic                     enb,
    input  logic [DATA_W/BYTE_W-1:0] web,
    input  logic [ADDR_W-1:0]        addrb,
    input  logic [DATA_W-1:0]        dib,
    output logic [DATA_W-1:0]        dob,
    output logic                     valb,
    output logic                     coll
);

    localparam int  NBE        = DATA_W / BYTE_W;
    localparam int  DEPTH      = 2 ** ADDR_W;
    localparam bit  WRITE_FRST = (WR_MODE == int'(WRITE_FIRST));

    // Storage is deliberately left out of reset so contents survive rst_n pulses
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] mask_a, mask_b;
    logic              wr_a, wr_b, same_addr, wr_hit;
    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W-1:0] word_a, word_b;
    logic [DATA_W-1:0] new_a, new_b;

    logic [DATA_W-1:0] rd_a, rd_b;
    logic              val_a, val_b, coll_q;

    // Expand per-lane write enables into per-bit masks
    for (genvar g = 0; g < NBE; g++) begin : g_mask
        assign mask_a[g*BYTE_W +: BYTE_W] = {BYTE_W{wea[g]}};
        assign mask_b[g*BYTE_W +: BYTE_W] = {BYTE_W{web[g]}};
    end

    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [DATA_W-1:0] bit_mask
    );
        return DATA_W'(lane_merge(MERGE_W'(old_word), MERGE_W'(new_word), MERGE_W'(bit_mask)));
    endfunction

    // Build the words each port will store; on a same-address double write
    // port A merges on top of B's result so A wins overlapping lanes only
    always_comb begin
        wr_a      = ena && (|wea);
        wr_b      = enb && (|web);
        same_addr = (addra == addrb);
        old_a     = mem[addra];
        old_b     = mem[addrb];
        word_b    = merge_word(old_b, dib, mask_b);
        word_a    = merge_word((wr_b && same_addr) ? word_b : old_a, dia, mask_a);
        wr_hit    = wr_a && wr_b && same_addr && (|(wea & web));
        // Write-first returns what actually lands in the array, including the other port's lanes
        new_a     = wr_a ? word_a : old_a;
        new_b     = wr_b ? ((wr_a && same_addr) ? word_a : word_b) : old_b;
    end

    // Array writes, suppressed while reset is held; A is written last so it wins
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wr_b) begin
                mem[addrb] <= word_b;
            end
            if (wr_a) begin
                mem[addra] <= word_a;
            end
        end
    end

    // First read stage: data holds when a port is idle, valid tracks the enable.
    // Cross-port reads always see the pre-write word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_a   <= '0;
            rd_b   <= '0;
            val_a  <= 1'b0;
            val_b  <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            if (ena) begin
                rd_a <= WRITE_FRST ? new_a : old_a;
            end
            if (enb) begin
                rd_b <= WRITE_FRST ? new_b : old_b;
            end
            val_a  <= ena;
            val_b  <= enb;
            coll_q <= wr_hit;
        end
    end

    tdp_ram_outreg #(
        .DATA_W (DATA_W)
    ) u_out_a (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rd_a),
        .vin   (val_a),
        .dout  (doa),
        .vout  (vala)
    );

    tdp_ram_outreg #(
        .DATA_W (DATA_W)
    ) u_out_b (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rd_b),
        .vin   (val_b),
        .dout  (dob),
        .vout  (valb)
    );

`ifdef TDP_RAM_OUT_REG_EN
    logic coll_d;

    // Delay the collision flag so it stays aligned with the registered read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_d <= 1'b0;
        end else begin
            coll_d <= coll_q;
        end
    end

    assign coll = coll_d;
`else
    assign coll = coll_q;
`endif

endmodule

// File: tb/tb_tdp_ram.sv
// tb/tb_tdp_ram.sv - self-checking scoreboard bench for tdp_ram (honours TDP_RAM_OUT_REG_EN)
module tb_tdp_ram;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 5;
    localparam int BYTE_W  = 4;
    localparam int NBE     = DATA_W / BYTE_W;
    localparam int WR_MODE = 0;
`ifdef TDP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena, enb;
    logic [NBE-1:0]    wea, web;
    logic [ADDR_W-1:0] addra, addrb;
    logic [DATA_W-1:0] dia, dib;
    logic [DATA_W-1:0] doa, dob;
    logic              vala, valb, coll;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] exp_a[$];
    logic [DATA_W-1:0] exp_b[$];

    tdp_ram #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYTE_W  (BYTE_W),
        .WR_MODE (WR_MODE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dia   (dia),
        .doa   (doa),
        .vala  (vala),
        .enb   (enb),
        .web   (web),
        .addrb (addrb),
        .dib   (dib),
        .dob   (dob),
        .valb  (valb),
        .coll  (coll)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; wea = '0;
        enb = 1'b0; web = '0;
    endtask

    task automatic write_a(input logic [NBE-1:0] we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data);
        ena = 1'b1; wea = we; addra = addr; dia = data;
        cycle();
        idle();
        repeat (3) cycle();
    endtask

    task automatic read_a(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data,
                          output int lat);
        ena = 1'b1; wea = '0; addra = addr;
        cycle();
        idle();
        lat = 1;
        while (!vala && lat < 6) begin
            cycle();
            lat++;
        end
        data = doa;
    endtask

    task automatic read_b(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data,
                          output int lat);
        enb = 1'b1; web = '0; addrb = addr;
        cycle();
        idle();
        lat = 1;
        while (!valb && lat < 6) begin
            cycle();
            lat++;
        end
        data = dob;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cycle();
        n_tests++; if (doa !== 8'h00) begin n_fail++; $display("FAIL reset_doa got=%h exp=00", doa); end
        n_tests++; if (dob !== 8'h00) begin n_fail++; $display("FAIL reset_dob got=%h exp=00", dob); end
        n_tests++; if (vala !== 1'b0) begin n_fail++; $display("FAIL reset_vala got=%b exp=0", vala); end
        n_tests++; if (valb !== 1'b0) begin n_fail++; $display("FAIL reset_valb got=%b exp=0", valb); end
        n_tests++; if (coll !== 1'b0) begin n_fail++; $display("FAIL reset_coll got=%b exp=0", coll); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] d, e;
        int lat;
        write_a(2'b11, 5'd2, 8'hA5);
        exp_b.push_back(8'hA5);
        read_b(5'd2, d, lat);
        e = exp_b.pop_front();
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL basic_dob got=%h exp=%h", d, e); end
        n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        cycle();
        n_tests++; if (valb !== 1'b0) begin n_fail++; $display("FAIL idle_valb got=%b exp=0", valb); end
        n_tests++; if (dob !== e) begin n_fail++; $display("FAIL idle_dob_hold got=%h exp=%h", dob, e); end
    endtask

    task automatic test_lane_write();
        logic [DATA_W-1:0] d, e;
        int lat;
        write_a(2'b01, 5'd2, 8'h3C);
        exp_a.push_back(8'hAC);
        read_a(5'd2, d, lat);
        e = exp_a.pop_front();
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL lane_write got=%h exp=%h", d, e); end
        n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL lane_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_same_port();
        logic [DATA_W-1:0] d, e;
        int lat;
        write_a(2'b11, 5'd4, 8'h77);
        exp_a.push_back((WR_MODE == 0) ? 8'h77 : 8'h11);
        ena = 1'b1; wea = 2'b11; addra = 5'd4; dia = 8'h11;
        cycle();
        idle();
        lat = 1;
        while (!vala && lat < 6) begin cycle(); lat++; end
        e = exp_a.pop_front();
        n_tests++; if (doa !== e) begin n_fail++; $display("FAIL same_port_rdw got=%h exp=%h", doa, e); end
        repeat (3) cycle();
        exp_a.push_back(8'h11);
        read_a(5'd4, d, lat);
        e = exp_a.pop_front();
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL same_port_store got=%h exp=%h", d, e); end
    endtask

    task automatic test_cross_port();
        logic [DATA_W-1:0] e;
        int lat;
        exp_b.push_back(8'h11);
        ena = 1'b1; wea = 2'b11; addra = 5'd4; dia = 8'h99;
        enb = 1'b1; web = 2'b00; addrb = 5'd4;
        cycle();
        idle();
        lat = 1;
        while (!valb && lat < 6) begin cycle(); lat++; end
        e = exp_b.pop_front();
        n_tests++; if (dob !== e) begin n_fail++; $display("FAIL cross_port_old got=%h exp=%h", dob, e); end
        repeat (3) cycle();
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] d, e;
        int lat;
        ena = 1'b1; wea = 2'b10; addra = 5'd31; dia = 8'h12;
        enb = 1'b1; web = 2'b11; addrb = 5'd31; dib = 8'h34;
        cycle();
        idle();
        for (int k = 1; k <= 4; k++) begin
            n_tests++;
            if (coll !== (k == LAT)) begin
                n_fail++; $display("FAIL coll_pulse cycle=%0d got=%b exp=%b", k, coll, (k == LAT));
            end
            cycle();
        end
        exp_b.push_back(8'h14);
        read_b(5'd31, d, lat);
        e = exp_b.pop_front();
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL coll_merge got=%h exp=%h", d, e); end
        ena = 1'b1; wea = 2'b10; addra = 5'd31; dia = 8'h50;
        enb = 1'b1; web = 2'b01; addrb = 5'd31; dib = 8'h06;
        cycle();
        idle();
        for (int k = 1; k <= 4; k++) begin
            n_tests++;
            if (coll !== 1'b0) begin n_fail++; $display("FAIL no_coll cycle=%0d got=%b exp=0", k, coll); end
            cycle();
        end
        exp_a.push_back(8'h56);
        read_a(5'd31, d, lat);
        e = exp_a.pop_front();
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL disjoint_merge got=%h exp=%h", d, e); end
    endtask

    task automatic test_retention();
        logic [DATA_W-1:0] d, e;
        int lat;
        write_a(2'b11, 5'd0, 8'h5A);
        write_a(2'b11, 5'd1, 8'h33);
        rst_n = 1'b0;
        ena = 1'b1; wea = 2'b11; addra = 5'd1; dia = 8'hEE;
        cycle();
        idle();
        rst_n = 1'b1;
        n_tests++; if (vala !== 1'b0) begin n_fail++; $display("FAIL rst_pulse_vala got=%b exp=0", vala); end
        n_tests++; if (doa !== 8'h00) begin n_fail++; $display("FAIL rst_pulse_doa got=%h exp=00", doa); end
        exp_a.push_back(8'h5A);
        read_a(5'd0, d, lat);
        e = exp_a.pop_front();
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL retention got=%h exp=%h", d, e); end
        n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL post_reset_latency got=%0d exp=%0d", lat, LAT); end
        exp_b.push_back(8'h33);
        read_b(5'd1, d, lat);
        e = exp_b.pop_front();
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL reset_blocks_write got=%h exp=%h", d, e); end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addrs [4];
        logic [DATA_W-1:0] vals  [4];
        logic [DATA_W-1:0] e;
        int seen;
        addrs[0] = 5'd0;  vals[0] = 8'h5A;
        addrs[1] = 5'd2;  vals[1] = 8'hAC;
        addrs[2] = 5'd4;  vals[2] = 8'h99;
        addrs[3] = 5'd31; vals[3] = 8'h56;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            enb = 1'b1; web = '0; addrb = addrs[i];
            exp_b.push_back(vals[i]);
            cycle();
            if (valb && exp_b.size() > 0) begin
                e = exp_b.pop_front();
                seen++;
                n_tests++; if (dob !== e) begin n_fail++; $display("FAIL b2b_read idx=%0d got=%h exp=%h", seen, dob, e); end
            end
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            if (valb && exp_b.size() > 0) begin
                e = exp_b.pop_front();
                seen++;
                n_tests++; if (dob !== e) begin n_fail++; $display("FAIL b2b_read idx=%0d got=%h exp=%h", seen, dob, e); end
            end
            cycle();
        end
        n_tests++; if (seen !== 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", seen); end
        n_tests++; if (exp_a.size() + exp_b.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_empty got=%0d exp=0", exp_a.size() + exp_b.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b0; wea = '0; addra = '0; dia = '0;
        enb = 1'b0; web = '0; addrb = '0; dib = '0;
        test_reset();
        test_basic();
        test_lane_write();
        test_same_port();
        test_cross_port();
        test_collision();
        test_retention();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
